// File: rtl/div_clk_monitor_if.sv
// Bundle of the monitored slow clock, error-clear control and status outputs
// shared between div_clk_monitor and whatever drives/observes it.
interface div_clk_monitor_if #(
  parameter int CNT_W = 32
);
  logic             div_clk;
  logic             clr_err;
  logic [CNT_W-1:0] half_period;
  logic             period_valid;
  logic             in_window;
  logic             locked;
  logic             lost;
  logic [7:0]       err_cnt;

  modport master (
    output div_clk, clr_err,
    input  half_period, period_valid, in_window, locked, lost, err_cnt
  );

  modport slave (
    input  div_clk, clr_err,
    output half_period, period_valid, in_window, locked, lost, err_cnt
  );
endinterface

// File: rtl/div_clk_monitor.sv
// Measures each half-period of an asynchronous slow clock in clk cycles and reports
// lock, loss of signal and a saturating error count. Optional: DIV_CLK_DUTY_CHECK_EN.
module div_clk_monitor #(
  parameter int               CNT_W   = 32,
  parameter logic [CNT_W-1:0] EXPECT  = 32'd25000001,
  parameter logic [CNT_W-1:0] TOL     = 32'd16,
  parameter logic [CNT_W-1:0] TIMEOUT = 32'd50000000,
  parameter int               LOCK_N  = 2
) (
  input logic              clk,
  input logic              reset,
  div_clk_monitor_if.slave mon
);

  typedef enum logic [1:0] {WAIT_EDGE, MEASURE, LOCKED} state_t;

  // Window bounds are one bit wider so EXPECT+TOL cannot wrap
  localparam logic [CNT_W:0] WIN_LO   = (EXPECT >= TOL) ? ({1'b0, EXPECT} - {1'b0, TOL}) : '0;
  localparam logic [CNT_W:0] WIN_HI   = {1'b0, EXPECT} + {1'b0, TOL};
  localparam logic [4:0]     LOCK_TGT = 5'(LOCK_N);

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       good_run;
  logic             div_edge;
  logic [CNT_W:0]   meas;
  logic             win_now;
  logic             meas_ok;
  logic             timeout;
  logic             err_bump;

  assign div_edge = s2 ^ s3;
  assign meas     = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign win_now  = (meas >= WIN_LO) && (meas <= WIN_HI);
  assign timeout  = !div_edge && (cnt == TIMEOUT);
  assign err_bump = (state == LOCKED) && ((div_edge && !meas_ok) || timeout);

`ifdef DIV_CLK_DUTY_CHECK_EN
  logic [CNT_W:0] prev_m;
  logic [CNT_W:0] m_diff;

  assign m_diff  = (meas >= prev_m) ? (meas - prev_m) : (prev_m - meas);
  assign meas_ok = win_now && !((state == LOCKED) && (m_diff > {1'b0, TOL}));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_m <= '0;
    end else if (state != WAIT_EDGE) begin
      if (div_edge) begin
        prev_m <= meas;
      end else if (timeout) begin
        prev_m <= '0;
      end
    end
  end
`else
  assign meas_ok = win_now;
`endif

  // Two-flop synchroniser plus history flop for both-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon.div_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (div_edge) begin
      cnt <= '0;
    end else if (cnt != TIMEOUT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Clear has priority over an increment landing in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mon.err_cnt <= '0;
    end else if (mon.clr_err) begin
      mon.err_cnt <= '0;
    end else if (err_bump && (mon.err_cnt != 8'hFF)) begin
      mon.err_cnt <= mon.err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= WAIT_EDGE;
      good_run         <= '0;
      mon.half_period  <= '0;
      mon.period_valid <= 1'b0;
      mon.in_window    <= 1'b0;
      mon.locked       <= 1'b0;
      mon.lost         <= 1'b0;
    end else begin
      mon.period_valid <= 1'b0;
      case (state)
        WAIT_EDGE: begin
          if (div_edge) begin
            state    <= MEASURE;
            mon.lost <= 1'b0;
          end else if (cnt == TIMEOUT) begin
            mon.lost <= 1'b1;
          end
        end
        MEASURE, LOCKED: begin
          if (div_edge) begin
            mon.half_period  <= meas[CNT_W-1:0];
            mon.period_valid <= 1'b1;
            mon.in_window    <= meas_ok;
            if (!meas_ok) begin
              good_run   <= '0;
              mon.locked <= 1'b0;
              state      <= MEASURE;
            end else if (state == MEASURE) begin
              good_run <= good_run + 4'd1;
              if (({1'b0, good_run} + 5'd1) >= LOCK_TGT) begin
                state      <= LOCKED;
                mon.locked <= 1'b1;
              end
            end
          end else if (timeout) begin
            mon.lost   <= 1'b1;
            mon.locked <= 1'b0;
            good_run   <= '0;
            state      <= WAIT_EDGE;
          end
        end
        default: state <= WAIT_EDGE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Randomised bench for div_clk_monitor: drives half-periods of chosen length and
// compares status against an event-level model of the monitor's rules.
module tb_div_clk_monitor;

  localparam int EXP = 10;
  localparam int TLV = 1;
  localparam int TMO = 40;
  localparam int LN  = 2;

  logic clk;
  logic reset;

  div_clk_monitor_if #(.CNT_W(32)) bus ();

  div_clk_monitor #(
    .CNT_W  (32),
    .EXPECT (32'd10),
    .TOL    (32'd1),
    .TIMEOUT(32'd40),
    .LOCK_N (LN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mon  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, advanced once per driven div_clk transition
  bit haveRef;
  bit mLocked;
  bit mLost;
  bit mWin;
  bit expPulse;
  int mHalf;
  int run;
  int errs;
  int prevMeas;
  int hPrev;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    haveRef = 0; mLocked = 0; mLost = 0; mWin = 0; expPulse = 0;
    mHalf = 0; run = 0; errs = 0; prevMeas = 0; hPrev = 0;
  endtask

  task automatic modelToggle(input int m, input bit clr);
    bit ok;
    int d;
    expPulse = 0;
    if (!haveRef) begin
      haveRef = 1;
      mLost   = 0;
    end else begin
      expPulse = 1;
      mHalf    = m;
      ok       = (m >= EXP - TLV) && (m <= EXP + TLV);
`ifdef DIV_CLK_DUTY_CHECK_EN
      d = (m > prevMeas) ? m - prevMeas : prevMeas - m;
      if (mLocked && ok && d > TLV) ok = 0;
`else
      d = 0;
`endif
      prevMeas = m;
      mWin     = ok;
      if (mLocked) begin
        if (!ok) begin
          if (errs < 255) errs++;
          mLocked = 0;
          run     = 0;
        end
      end else if (ok) begin
        run++;
        if (run >= LN) mLocked = 1;
      end else begin
        run = 0;
      end
    end
    if (clr) errs = 0;
  endtask

  task automatic modelTimeout();
    if (mLocked && errs < 255) errs++;
    mLocked  = 0;
    run      = 0;
    mLost    = 1;
    haveRef  = 0;
    prevMeas = 0;
  endtask

  // Toggle div_clk now (at a falling clk edge), hold it for h cycles, then check
  task automatic applyStimulus(input int h, input bit clr);
    int  pulses;
    int  pulseAt;
    int  lostAt;
    bit  tmo;
    bus.div_clk = ~bus.div_clk;
    pulses  = 0;
    pulseAt = 0;
    lostAt  = 0;
    for (int s = 1; s <= h; s++) begin
      @(negedge clk);
      if (bus.period_valid) begin
        pulses++;
        pulseAt = s;
      end
      if (bus.lost && lostAt == 0 && s > 3) lostAt = s;
      if (clr && s == 2) bus.clr_err = 1'b1;
      if (s == 3) bus.clr_err = 1'b0;
    end
    modelToggle(hPrev, clr);
    tmo = (h >= TMO + 2);
    if (tmo) modelTimeout();
    hPrev = h;
    checkOutput("pulse_count", pulses, expPulse);
    if (expPulse) checkOutput("pulse_slot", pulseAt, 3);
    if (tmo) checkOutput("lost_time", lostAt, TMO + 4);
    checkOutput("half_period", bus.half_period, mHalf);
    checkOutput("in_window", {31'b0, bus.in_window}, {31'b0, mWin});
    checkOutput("locked", {31'b0, bus.locked}, {31'b0, mLocked});
    checkOutput("lost", {31'b0, bus.lost}, {31'b0, mLost});
    checkOutput("err_cnt", {24'b0, bus.err_cnt}, errs);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_half"}, bus.half_period, 0);
    checkOutput({tag, "_pv"}, {31'b0, bus.period_valid}, 0);
    checkOutput({tag, "_win"}, {31'b0, bus.in_window}, 0);
    checkOutput({tag, "_lock"}, {31'b0, bus.locked}, 0);
    checkOutput({tag, "_lost"}, {31'b0, bus.lost}, 0);
    checkOutput({tag, "_err"}, {24'b0, bus.err_cnt}, 0);
  endtask

  // Reset asynchronously part-way through a half-period
  task automatic resetMidway();
    bus.div_clk = ~bus.div_clk;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1 checkAllZero("rst_mid");
    repeat (3) @(negedge clk);
    checkAllZero("rst_hold");
    bus.div_clk = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    modelReset();
  endtask

  initial begin
    int r;
    int h;
    reset       = 1'b0;
    bus.div_clk = 1'b0;
    bus.clr_err = 1'b0;
    modelReset();
    @(negedge clk);
    #1 checkAllZero("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Dead input straight after reset
    repeat (30) @(negedge clk);
    checkOutput("dead_early", {31'b0, bus.lost}, 0);
    repeat (20) @(negedge clk);
    checkOutput("dead_late", {31'b0, bus.lost}, 1);
    mLost = 1;

    repeat (6) applyStimulus(10, 0);
    applyStimulus(13, 0);
    repeat (3) applyStimulus(10, 0);
    applyStimulus(60, 0);
    repeat (4) applyStimulus(10, 0);
    applyStimulus(41, 0);
    repeat (3) applyStimulus(10, 0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(13, 0);
      applyStimulus(10, 0);
      applyStimulus(10, 0);
    end
    applyStimulus(10, 0);
    applyStimulus(13, 0);
    applyStimulus(10, 1);
    repeat (3) applyStimulus(10, 0);
    applyStimulus(13, 0);
    applyStimulus(10, 0);

    resetMidway();
    repeat (5) applyStimulus(9, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(11, 0);
      applyStimulus(9, 0);
    end

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      h = $urandom_range(9, 11);
      else if (r < 85) h = $urandom_range(4, 20);
      else if (r < 92) h = TMO + 1;
      else             h = $urandom_range(TMO + 4, TMO + 15);
      applyStimulus(h, ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
- Receive-side counterpart to the team's clock dividers.
- Samples a slow divided clock (div_clk) generated elsewhere and measures each half-period in system clk cycles.
- Checks every measurement against an expected value and tolerance, and reports lock, loss of signal and an error count.
- Sits between a divider output (or an external slow clock pin) and the status/LED logic.

Parameters:
- CNT_W, 32, width of the measurement counter and the half_period output.
- EXPECT, 32'd25000001, expected half-period in clk cycles.
- TOL, 32'd16, allowed absolute deviation from EXPECT, inclusive.
- TIMEOUT, 32'd50000000, cycles without a detected edge before the signal is declared lost. Must satisfy TIMEOUT > EXPECT+TOL and TIMEOUT < 2^CNT_W.
- LOCK_N, 2, consecutive in-window measurements required to assert locked (range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low; 0 resets all state
- div_clk  in  1  monitored slow clock, asynchronous to clk
- clr_err  in  1  synchronous clear of err_cnt
- half_period  out  CNT_W  last measured half-period, in clk cycles
- period_valid  out  1  one-cycle pulse when half_period updates
- in_window  out  1  last measurement was within EXPECT±TOL
- locked  out  1  monitor is locked to div_clk
- lost  out  1  no edge detected for TIMEOUT cycles
- err_cnt  out  8  saturating error count

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; sync flops 0; cnt=0; good_run=0; state=WAIT_EDGE.
- Synchroniser:
  - div_clk passes through two flops (s1, s2), then a history flop s3.
  - edge = s2 XOR s3; both rising and falling edges count.
  - A div_clk transition first sampled at clock edge k gives edge=1 during the cycle after edge k+1.
- Counter cnt:
  - When edge=1: cnt<=0.
  - Otherwise cnt<=cnt+1, saturating at TIMEOUT.
- Measurement m = cnt+1, taken in the edge cycle. This is the exact number of clk cycles between consecutive detected edges.
- Window check: in_window_now = (m >= EXPECT-TOL) && (m <= EXPECT+TOL). Compute in CNT_W+1 bits. If EXPECT < TOL, the lower bound is 0.
- All outputs are registered and update at the end of the edge cycle.
- States:
  - WAIT_EDGE:
    - No reference edge yet.
    - On edge: go to MEASURE, clear lost. No period_valid pulse on this first edge.
  - MEASURE:
    - On edge: half_period<=m, period_valid<=1, in_window<=in_window_now.
    - If in window: good_run++. When good_run reaches LOCK_N, go to LOCKED and set locked<=1.
    - If out of window: good_run<=0 and stay in MEASURE. err_cnt is not incremented while unlocked.
  - LOCKED:
    - On edge: publish half_period, period_valid and in_window exactly as in MEASURE.
    - If out of window: err_cnt++, locked<=0, good_run<=0, go to MEASURE.
- Timeout, in MEASURE or LOCKED:
  - Triggered when cnt==TIMEOUT and edge=0.
  - lost<=1, locked<=0, good_run<=0, go to WAIT_EDGE.
  - If timeout occurs from LOCKED, err_cnt++.
  - lost stays set until the next detected edge.
- Timeout in WAIT_EDGE: cnt saturates and lost<=1. This covers a dead input after reset.
- err_cnt:
  - Saturates at 255.
  - clr_err=1 sets err_cnt<=0.
  - If clr_err and an increment occur in the same cycle, the clear wins.
- Simultaneous edge and cnt==TIMEOUT: the edge wins and no timeout occurs.
- Reset asserted mid-measurement: everything returns to reset values immediately. The first edge after release is only a reference edge.

Optional Feature:
- Macro: DIV_CLK_DUTY_CHECK_EN.
- Defined:
  - The monitor keeps the previous measurement, prev_m.
  - In LOCKED, a measurement that is in window but has |m - prev_m| > TOL counts as out-of-window: err_cnt++, unlock, go to MEASURE.
  - The in_window output reflects this combined check.
  - prev_m is cleared on reset and on timeout. The prev_m check is skipped for the first measurement after WAIT_EDGE.
- Not defined: only the per-measurement EXPECT±TOL check applies; no prev_m register exists.

Test Plan (EXPECT=10, TOL=1, TIMEOUT=40, LOCK_N=2):
- Toggle div_clk every 10 clk from reset release -> no pulse at the first edge; then a period_valid pulse every 10 cycles with half_period=10; locked=1 after the 2nd valid pulse; err_cnt=0.
- While locked, one half of 13 cycles -> half_period=13, in_window=0, locked=0, err_cnt=1; relock after two further halves of 10.
- While locked, hold div_clk static -> lost=1 and locked=0 exactly 41 cycles after the last edge cycle; err_cnt +1; the next edge clears lost without a pulse, and the following edge gives a pulse.
- Force 300 out-of-window relock cycles -> err_cnt stops at 255; pulse clr_err in the same cycle as an error -> err_cnt=0.
- Assert reset mid-half-period, release, toggle every 9 cycles -> all outputs 0 during reset; half_period=9 accepted (within ±1); locked after 2 measurements.
- With DIV_CLK_DUTY_CHECK_EN defined, alternate halves of 9 and 11 after lock -> diff 2 > TOL, so in_window=0 and err_cnt increments; without the macro, lock is held.
